// File: rtl/stim_hbridge_drv_pkg.sv
// Shared types for the H-bridge output stage: phase and FSM encodings,
// the switch-enable bundle and the phase-to-switch decode.
package stim_hbridge_drv_pkg;

    typedef enum logic [1:0] {
        PH_OFF   = 2'd0,
        PH_POS   = 2'd1,
        PH_NEG   = 2'd2,
        PH_SHORT = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_DEAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_ON     = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    typedef struct packed {
        logic ano_top;
        logic ano_bot;
        logic cat_top;
        logic cat_bot;
    } bridge_sw_t;

    // Each leg only ever closes one side, so no decode can produce shoot-through.
    function automatic bridge_sw_t phase_to_sw(input phase_t ph);
        bridge_sw_t sw;
        sw = '0;
        case (ph)
            PH_POS:   begin sw.ano_top = 1'b1; sw.cat_bot = 1'b1; end
            PH_NEG:   begin sw.cat_top = 1'b1; sw.ano_bot = 1'b1; end
            PH_SHORT: begin sw.ano_bot = 1'b1; sw.cat_bot = 1'b1; end
            default:  sw = '0;
        endcase
        return sw;
    endfunction

    function automatic logic is_drive(input phase_t ph);
        return (ph == PH_POS) || (ph == PH_NEG);
    endfunction

    function automatic int cnt_width(input int val);
        return (val < 1) ? 1 : $clog2(val + 1);
    endfunction

endpackage

// File: rtl/stim_hbridge_drv_if.sv
// Command/bridge bundle between the pulse sequencer (master) and the
// H-bridge driver (slave).
interface stim_hbridge_drv_if;
    import stim_hbridge_drv_pkg::*;

    logic   en;
    logic   cmd_vld;
    phase_t cmd_phase;
    logic   cmd_rdy;
    logic   fault_clr;
    logic   ano_top;
    logic   ano_bot;
    logic   cat_top;
    logic   cat_bot;
    logic   curr_ena;
    phase_t cur_phase;
    logic   fault;

    modport master (
        output en, cmd_vld, cmd_phase, fault_clr,
        input  cmd_rdy, ano_top, ano_bot, cat_top, cat_bot, curr_ena, cur_phase, fault
    );

    modport slave (
        input  en, cmd_vld, cmd_phase, fault_clr,
        output cmd_rdy, ano_top, ano_bot, cat_top, cat_bot, curr_ena, cur_phase, fault
    );

endinterface

// File: rtl/stim_hbridge_drv_cycle_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module stim_hbridge_drv_cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    output logic             done
);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (count_en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - WIDTH'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/stim_hbridge_drv.sv
// H-bridge output stage: turns phase commands into break-before-make switch
// enables plus a current-source enable, with a continuous-drive watchdog.
module stim_hbridge_drv
    import stim_hbridge_drv_pkg::*;
#(
    parameter int DEAD_CYC   = 4,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_ON_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    stim_hbridge_drv_if.slave   bus
);

    localparam int DW  = cnt_width(DEAD_CYC);
    localparam int STW = cnt_width(SETTLE_CYC);
    localparam int WW  = cnt_width(MAX_ON_CYC);

    // Dead runs DEAD_CYC counted clocks plus the closing edge; settle and the
    // watchdog are loaded on the closing edge itself, hence the minus one.
    localparam logic [DW-1:0]  DEAD_LOAD   = DW'(DEAD_CYC);
    localparam logic [STW-1:0] SETTLE_LOAD = STW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [WW-1:0]  WD_LOAD     = WW'(MAX_ON_CYC - 1);

    state_t     state_reg, state_next;
    phase_t     tgt_reg, tgt_next;
    phase_t     phase_reg, phase_next;
    bridge_sw_t sw_reg, sw_next;
    logic       curr_ena_reg, curr_ena_next;
    logic       alive_reg;

    logic dead_load, settle_load, wd_load;
    logic dead_done, settle_done, wd_done;
    logic closed, cmd_take;

    assign closed   = (state_reg == S_SETTLE) || (state_reg == S_ON);
    assign bus.cmd_rdy = alive_reg && bus.en && ((state_reg == S_OFF) || (state_reg == S_ON));
    assign cmd_take = bus.cmd_vld && bus.cmd_rdy;

    stim_hbridge_drv_cycle_timer #(.WIDTH(DW)) u_dead (
        .clk      (clk),
        .rst      (rst),
        .load     (dead_load),
        .load_val (DEAD_LOAD),
        .count_en (state_reg == S_DEAD),
        .done     (dead_done)
    );

    stim_hbridge_drv_cycle_timer #(.WIDTH(STW)) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SETTLE_LOAD),
        .count_en (state_reg == S_SETTLE),
        .done     (settle_done)
    );

    stim_hbridge_drv_cycle_timer #(.WIDTH(WW)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .load     (wd_load),
        .load_val (WD_LOAD),
        .count_en (closed && is_drive(phase_reg)),
        .done     (wd_done)
    );

    always_comb begin
        state_next  = state_reg;
        tgt_next    = tgt_reg;
        phase_next  = phase_reg;
        dead_load   = 1'b0;
        settle_load = 1'b0;
        wd_load     = 1'b0;

        case (state_reg)
            S_OFF: begin
                if (cmd_take && (bus.cmd_phase != PH_OFF)) begin
                    state_next = S_DEAD;
                    tgt_next   = bus.cmd_phase;
                    dead_load  = 1'b1;
                end
            end
            S_DEAD: begin
                // Dropping enable retargets to OFF without restarting the gap.
                if (!bus.en) tgt_next = PH_OFF;
                if (dead_done) begin
                    if (tgt_next == PH_OFF) begin
                        state_next = S_OFF;
                    end else begin
                        phase_next = tgt_next;
                        state_next = S_ON;
                        if (is_drive(tgt_next)) begin
                            wd_load = 1'b1;
                            if (SETTLE_CYC > 0) begin
                                state_next  = S_SETTLE;
                                settle_load = 1'b1;
                            end
                        end
                    end
                end
            end
            S_SETTLE, S_ON: begin
                if (wd_done && is_drive(phase_reg)) begin
                    state_next = S_FAULT;
                    phase_next = PH_OFF;
                end else if (!bus.en) begin
                    state_next = S_DEAD;
                    tgt_next   = PH_OFF;
                    phase_next = PH_OFF;
                    dead_load  = 1'b1;
                end else if (state_reg == S_SETTLE) begin
                    if (settle_done) state_next = S_ON;
                end else if (cmd_take && (bus.cmd_phase != phase_reg)) begin
                    state_next = S_DEAD;
                    tgt_next   = bus.cmd_phase;
                    phase_next = PH_OFF;
                    dead_load  = 1'b1;
                end
            end
            S_FAULT: begin
                if (bus.fault_clr) state_next = S_OFF;
            end
            default: begin
                state_next = S_OFF;
                phase_next = PH_OFF;
            end
        endcase

        sw_next       = ((state_next == S_SETTLE) || (state_next == S_ON)) ? phase_to_sw(phase_next) : '0;
        curr_ena_next = (state_next == S_ON) && is_drive(phase_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_OFF;
            tgt_reg      <= PH_OFF;
            phase_reg    <= PH_OFF;
            sw_reg       <= '0;
            curr_ena_reg <= 1'b0;
            alive_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tgt_reg      <= tgt_next;
            phase_reg    <= phase_next;
            sw_reg       <= sw_next;
            curr_ena_reg <= curr_ena_next;
            alive_reg    <= 1'b1;
        end
    end

    assign bus.ano_top   = sw_reg.ano_top;
    assign bus.ano_bot   = sw_reg.ano_bot;
    assign bus.cat_top   = sw_reg.cat_top;
    assign bus.cat_bot   = sw_reg.cat_bot;
    assign bus.curr_ena  = curr_ena_reg;
    assign bus.cur_phase = phase_reg;
    assign bus.fault     = (state_reg == S_FAULT);

endmodule

// File: tb/tb_stim_hbridge_drv.sv
// Directed bench for the H-bridge driver (DEAD=4, SETTLE=2, MAX_ON=16) with a
// per-cycle shoot-through / dead-gap monitor.
module tb_stim_hbridge_drv;
    import stim_hbridge_drv_pkg::*;

    localparam logic [31:0] SW_OFF   = 32'h0;
    localparam logic [31:0] SW_POS   = 32'h9;
    localparam logic [31:0] SW_NEG   = 32'h6;
    localparam logic [31:0] SW_SHORT = 32'h5;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    stim_hbridge_drv_if bus();

    stim_hbridge_drv #(
        .DEAD_CYC   (4),
        .SETTLE_CYC (2),
        .MAX_ON_CYC (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sw();
        return 32'({bus.ano_top, bus.ano_bot, bus.cat_top, bus.cat_bot});
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input phase_t ph);
        bus.cmd_vld   = 1'b1;
        bus.cmd_phase = ph;
        step(1);
        bus.cmd_vld   = 1'b0;
        $display("txn t=%0t cmd=%s", $time, ph.name());
    endtask

    // Invariant monitor: no leg shoot-through, current only in POS/NEG, and
    // at least four open clocks between two different closed configurations.
    logic [31:0] last_cfg;
    int          open_run;
    always @(negedge clk) begin
        if (rst) begin
            last_cfg = SW_OFF;
            open_run = 0;
        end else begin
            check_eq("no_shoot", 32'({bus.ano_top & bus.ano_bot, bus.cat_top & bus.cat_bot}), 32'h0);
            check_eq("ena_phase", 32'(bus.curr_ena && !(bus.cur_phase == PH_POS || bus.cur_phase == PH_NEG)), 32'h0);
            if (sw() != SW_OFF) begin
                if ((last_cfg != SW_OFF) && (sw() != last_cfg))
                    check_eq("dead_gap", 32'(open_run >= 4), 32'h1);
                last_cfg = sw();
                open_run = 0;
            end else begin
                open_run++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int closed;
        rst           = 1'b1;
        bus.en        = 1'b1;
        bus.cmd_vld   = 1'b0;
        bus.cmd_phase = PH_OFF;
        bus.fault_clr = 1'b0;

        // Reset state
        step(2);
        check_eq("rst_sw", sw(), SW_OFF);
        check_eq("rst_ena", 32'(bus.curr_ena), 32'h0);
        check_eq("rst_fault", 32'(bus.fault), 32'h0);
        check_eq("rst_phase", 32'(bus.cur_phase), 32'(PH_OFF));
        check_eq("rst_rdy", 32'(bus.cmd_rdy), 32'h0);
        rst = 1'b0;
        #1;
        check_eq("rel_rdy_low", 32'(bus.cmd_rdy), 32'h0);
        step(1);
        check_eq("rel_rdy_high", 32'(bus.cmd_rdy), 32'h1);

        // 1: POS from OFF - closes at t0+5, current at t0+7
        send(PH_POS);
        check_eq("t1_open", sw(), SW_OFF);
        check_eq("t1_rdy_dead", 32'(bus.cmd_rdy), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check_eq("t1_dead", sw(), SW_OFF);
        end
        step(1);
        check_eq("t1_close", sw(), SW_POS);
        check_eq("t1_phase", 32'(bus.cur_phase), 32'(PH_POS));
        check_eq("t1_ena5", 32'(bus.curr_ena), 32'h0);
        step(1);
        check_eq("t1_ena6", 32'(bus.curr_ena), 32'h0);
        step(1);
        check_eq("t1_ena7", 32'(bus.curr_ena), 32'h1);
        check_eq("t1_rdy_on", 32'(bus.cmd_rdy), 32'h1);

        // 2: POS -> NEG opens on the accepting edge
        send(PH_NEG);
        check_eq("t2_open", sw(), SW_OFF);
        check_eq("t2_ena", 32'(bus.curr_ena), 32'h0);
        check_eq("t2_phase", 32'(bus.cur_phase), 32'(PH_OFF));
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check_eq("t2_dead", sw(), SW_OFF);
        end
        step(1);
        check_eq("t2_close", sw(), SW_NEG);
        check_eq("t2_phase_neg", 32'(bus.cur_phase), 32'(PH_NEG));
        step(2);
        check_eq("t2_ena7", 32'(bus.curr_ena), 32'h1);

        // 5: repeated same-phase cmds do not restart the watchdog
        for (int c = 8; c <= 21; c++) begin
            bus.cmd_vld   = (c % 5 == 0);
            bus.cmd_phase = PH_NEG;
            step(1);
            bus.cmd_vld   = 1'b0;
            if (c == 20) begin
                check_eq("t5_still_on", sw(), SW_NEG);
                check_eq("t5_no_fault", 32'(bus.fault), 32'h0);
            end
            if (c == 21) begin
                check_eq("t5_fault", 32'(bus.fault), 32'h1);
                check_eq("t5_open", sw(), SW_OFF);
                check_eq("t5_ena", 32'(bus.curr_ena), 32'h0);
                check_eq("t5_rdy", 32'(bus.cmd_rdy), 32'h0);
            end
        end
        $display("txn t=%0t watchdog fault (NEG)", $time);

        // 3: commands ignored in fault, then clear
        bus.cmd_vld   = 1'b1;
        bus.cmd_phase = PH_POS;
        step(3);
        bus.cmd_vld   = 1'b0;
        check_eq("t3_ign_fault", 32'(bus.fault), 32'h1);
        check_eq("t3_ign_rdy", 32'(bus.cmd_rdy), 32'h0);
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        $display("txn t=%0t fault_clr", $time);
        check_eq("t3_clr_fault", 32'(bus.fault), 32'h0);
        check_eq("t3_clr_rdy", 32'(bus.cmd_rdy), 32'h1);
        step(6);
        check_eq("t3_no_drive", sw(), SW_OFF);
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        check_eq("t3_clr_idle", 32'(bus.cmd_rdy), 32'h1);

        // 3: hold POS -> exactly 16 closed clocks before fault
        send(PH_POS);
        closed = 0;
        for (int i = 0; i < 40 && !bus.fault; i++) begin
            if (sw() == SW_POS) closed++;
            step(1);
        end
        check_eq("t3_fault", 32'(bus.fault), 32'h1);
        check_eq("t3_closed_cnt", 32'(closed), 32'd16);
        check_eq("t3_open", sw(), SW_OFF);
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;

        // 4: enable dropped during dead time toward NEG
        send(PH_NEG);
        step(2);
        bus.en = 1'b0;
        step(1);
        check_eq("t4_rdy_en0", 32'(bus.cmd_rdy), 32'h0);
        bus.en = 1'b1;
        #1;
        check_eq("t4_rdy_dead", 32'(bus.cmd_rdy), 32'h0);
        step(1);
        check_eq("t4_open4", sw(), SW_OFF);
        step(1);
        check_eq("t4_rdy_off", 32'(bus.cmd_rdy), 32'h1);
        check_eq("t4_open5", sw(), SW_OFF);
        check_eq("t4_phase", 32'(bus.cur_phase), 32'(PH_OFF));
        step(3);
        check_eq("t4_stay_open", sw(), SW_OFF);
        bus.en = 1'b0;
        #1;
        check_eq("t4_follow0", 32'(bus.cmd_rdy), 32'h0);
        bus.en = 1'b1;
        #1;
        check_eq("t4_follow1", 32'(bus.cmd_rdy), 32'h1);

        // SHORT has no current and no watchdog; enable drop forces OFF
        send(PH_SHORT);
        step(5);
        check_eq("sh_close", sw(), SW_SHORT);
        check_eq("sh_phase", 32'(bus.cur_phase), 32'(PH_SHORT));
        check_eq("sh_ena", 32'(bus.curr_ena), 32'h0);
        step(20);
        check_eq("sh_no_wd", sw(), SW_SHORT);
        check_eq("sh_no_fault", 32'(bus.fault), 32'h0);
        bus.en = 1'b0;
        step(1);
        bus.en = 1'b1;
        check_eq("sh_force_open", sw(), SW_OFF);
        check_eq("sh_force_phase", 32'(bus.cur_phase), 32'(PH_OFF));
        step(5);
        check_eq("sh_back_off", 32'(bus.cmd_rdy), 32'h1);
        check_eq("sh_stay_open", sw(), SW_OFF);

        // 6: asynchronous reset between edges
        send(PH_POS);
        step(7);
        check_eq("t6_on", 32'(bus.curr_ena), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        $display("txn t=%0t async reset", $time);
        check_eq("t6_sw", sw(), SW_OFF);
        check_eq("t6_ena", 32'(bus.curr_ena), 32'h0);
        check_eq("t6_phase", 32'(bus.cur_phase), 32'(PH_OFF));
        check_eq("t6_rdy", 32'(bus.cmd_rdy), 32'h0);
        #2;
        rst = 1'b0;
        step(2);
        check_eq("t6_rdy_back", 32'(bus.cmd_rdy), 32'h1);
        check_eq("t6_sw_back", sw(), SW_OFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
